// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours: hazard controls, decode
// redirects, the imem read port and the IF/ID register outputs.
interface fetch_stage_if;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] FetchCount;

    // The fetch stage itself sees the bundle through the slave view.
    modport slave (
        input  StallF, StallD, FlushD,
        input  PCSrcD, PCBranchD, JumpD, PCJumpD,
        input  InstrF,
        output PCF, InstrD, PCPlus4D, ValidD, FetchCount
    );

    modport master (
        output StallF, StallD, FlushD,
        output PCSrcD, PCBranchD, JumpD, PCJumpD,
        output InstrF,
        input  PCF, InstrD, PCPlus4D, ValidD, FetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: program counter, next-PC selection, the IF/ID
// pipeline register and a counter of valid instructions handed to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    logic [31:0] pcReg;
    logic [31:0] pcPlus4F;
    logic [31:0] pcNextF;
    logic [31:0] instrReg;
    logic [31:0] pcPlus4Reg;
    logic        validReg;
    logic [31:0] fetchCountReg;
    logic        loadValid;

    // Jump outranks a taken branch; targets are used unmasked and +4 wraps freely.
    always_comb begin
        pcPlus4F = pcReg + 32'd4;
        pcNextF  = pcPlus4F;
        if (bus.JumpD) begin
            pcNextF = bus.PCJumpD;
        end else if (bus.PCSrcD) begin
            pcNextF = bus.PCBranchD;
        end
    end

    // A stalled PC simply drops whatever redirect is presented alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg <= RESET_PC;
        end else if (!bus.StallF) begin
            pcReg <= pcNextF;
        end
    end

    // Stall beats flush, so a held instruction keeps its valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            instrReg   <= NOP_INSTR;
            pcPlus4Reg <= 32'd0;
            validReg   <= 1'b0;
        end else if (bus.StallD) begin
            instrReg   <= instrReg;
            pcPlus4Reg <= pcPlus4Reg;
            validReg   <= validReg;
        end else if (bus.FlushD) begin
            instrReg   <= NOP_INSTR;
            pcPlus4Reg <= 32'd0;
            validReg   <= 1'b0;
        end else begin
            instrReg   <= bus.InstrF;
            pcPlus4Reg <= pcPlus4F;
            validReg   <= 1'b1;
        end
    end

    assign loadValid = !bus.StallD && !bus.FlushD;

    // Counts only fresh loads, so a long stall contributes one instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchCountReg <= 32'd0;
        end else if (loadValid) begin
            fetchCountReg <= fetchCountReg + 32'd1;
        end
    end

    assign bus.PCF        = pcReg;
    assign bus.InstrD     = instrReg;
    assign bus.PCPlus4D   = pcPlus4Reg;
    assign bus.ValidD     = validReg;
    assign bus.FetchCount = fetchCountReg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed pipeline scenarios followed by random
// stall/flush/redirect/reset traffic, all compared against a cycle-level model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h00000000;
    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at A is 0x20080001 + (A/4)*0x00010001.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        return 32'h20080001 + (addr >> 2) * 32'h00010001;
    endfunction

    assign bus.InstrF = imem(bus.PCF);

    logic [31:0] mPC;
    logic [31:0] mInstrD;
    logic [31:0] mPCPlus4D;
    logic        mValidD;
    logic [31:0] mCount;

    // One clock edge of the architectural behaviour, from the current inputs.
    task automatic modelEdge();
        logic [31:0] seqPC;
        logic [31:0] target;
        if (reset) begin
            mPC       = RESET_PC;
            mInstrD   = NOP_INSTR;
            mPCPlus4D = 32'd0;
            mValidD   = 1'b0;
            mCount    = 32'd0;
        end else begin
            seqPC  = mPC + 32'd4;
            target = bus.JumpD ? bus.PCJumpD : (bus.PCSrcD ? bus.PCBranchD : seqPC);
            if (!bus.StallD) begin
                if (bus.FlushD) begin
                    mInstrD   = NOP_INSTR;
                    mPCPlus4D = 32'd0;
                    mValidD   = 1'b0;
                end else begin
                    mInstrD   = imem(mPC);
                    mPCPlus4D = seqPC;
                    mValidD   = 1'b1;
                    mCount    = mCount + 32'd1;
                end
            end
            if (!bus.StallF) mPC = target;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stallF, input logic stallD,
                                 input logic flushD, input logic pcSrc,
                                 input logic [31:0] branchT, input logic jump,
                                 input logic [31:0] jumpT);
        reset         = rst;
        bus.StallF    = stallF;
        bus.StallD    = stallD;
        bus.FlushD    = flushD;
        bus.PCSrcD    = pcSrc;
        bus.PCBranchD = branchT;
        bus.JumpD     = jump;
        bus.PCJumpD   = jumpT;
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("PCF",        bus.PCF,                 mPC);
        checkOutput("InstrD",     bus.InstrD,              mInstrD);
        checkOutput("PCPlus4D",   bus.PCPlus4D,            mPCPlus4D);
        checkOutput("ValidD",     {31'd0, bus.ValidD},     {31'd0, mValidD});
        checkOutput("FetchCount", bus.FetchCount,          mCount);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        mPC = 32'd0; mInstrD = 32'd0; mPCPlus4D = 32'd0; mValidD = 1'b0; mCount = 32'd0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (3) step();
        checkOutput("rst_pc",    bus.PCF,             32'h0);
        checkOutput("rst_valid", {31'd0, bus.ValidD}, 32'h0);
        checkOutput("rst_count", bus.FetchCount,      32'h0);

        idle();
        step();
        checkOutput("first_pc",    bus.PCF,             32'h4);
        checkOutput("first_instr", bus.InstrD,          32'h20080001);
        checkOutput("first_valid", {31'd0, bus.ValidD}, 32'h1);
        repeat (2) step();
        checkOutput("count3", bus.FetchCount, 32'd3);
        step();
        checkOutput("pc_0x10", bus.PCF, 32'h10);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (2) step();
        checkOutput("stall_pc",    bus.PCF,        32'h10);
        checkOutput("stall_p4",    bus.PCPlus4D,   32'h10);
        checkOutput("stall_instr", bus.InstrD,     32'h200B0004);
        checkOutput("stall_count", bus.FetchCount, 32'd4);
        idle();
        step();
        checkOutput("resume_pc",    bus.PCF,        32'h14);
        checkOutput("resume_count", bus.FetchCount, 32'd5);
        step();

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0);
        step();
        checkOutput("br_pc",    bus.PCF,             32'h40);
        checkOutput("br_valid", {31'd0, bus.ValidD}, 32'h0);
        checkOutput("br_instr", bus.InstrD,          NOP_INSTR);
        checkOutput("br_count", bus.FetchCount,      32'd6);
        idle();
        step();
        checkOutput("br_target_instr", bus.InstrD, 32'h20180011);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h78);
        step();
        checkOutput("jump_wins", bus.PCF, 32'h78);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
        step();
        checkOutput("stallf_drop", bus.PCF, 32'h78);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        checkOutput("stall_beats_flush", {31'd0, bus.ValidD}, 32'h1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h5C);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
        step();
        checkOutput("midrst_pc",    bus.PCF,             32'h0);
        checkOutput("midrst_valid", {31'd0, bus.ValidD}, 32'h0);
        checkOutput("midrst_count", bus.FetchCount,      32'h0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC);
        step();
        idle();
        step();
        checkOutput("wrap_pc", bus.PCF,      32'h0);
        checkOutput("wrap_p4", bus.PCPlus4D, 32'h0);

        // Random traffic, redirects sparse enough that sequential fetch dominates.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 6) == 0),
                          ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of decode.
- Owns the program counter (PCF) and the IF/ID pipeline register.
- Drives the instruction-memory address, accepts branch/jump redirects from decode, and honours stall/flush from the hazard unit.
- Also keeps a retired-fetch counter used by the benches for end-of-program checks.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000000, instruction word written into the IF/ID register on flush or reset (sll $0,$0,0).

Ports:
clk  input  1  rising-edge clock; the block's only clock.
reset  input  1  synchronous, active-high reset.
StallF  input  1  hold PCF this cycle.
StallD  input  1  hold the IF/ID register this cycle.
FlushD  input  1  bubble the IF/ID register this cycle.
PCSrcD  input  1  taken-branch redirect from decode.
PCBranchD  input  32  branch target.
JumpD  input  1  jump redirect from decode.
PCJumpD  input  32  jump target.
InstrF  input  32  instruction word from imem (combinational read of address PCF).
PCF  output  32  current fetch PC; drives imem address.
InstrD  output  32  registered instruction for decode.
PCPlus4D  output  32  registered PCF+4 for decode.
ValidD  output  1  1 = InstrD is a real fetched instruction; 0 = bubble.
FetchCount  output  32  number of valid instructions accepted into IF/ID since reset.

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous, active-high, and has top priority.
- Reset values:
  - PCF = RESET_PC.
  - InstrD = NOP_INSTR, PCPlus4D = 0, ValidD = 0, FetchCount = 0.
- PCPlus4F = PCF + 32'd4, combinational, modulo 2^32. At PCF = 32'hFFFFFFFC it wraps to 0; no exception is raised.
- Next-PC selection, in priority order:
  - JumpD = 1 → PCJumpD.
  - else PCSrcD = 1 → PCBranchD.
  - else PCPlus4F.
  - Jump and branch together: jump wins.
- PC register:
  - StallF = 1 → PCF holds, and any redirect presented that cycle is dropped.
  - StallF = 0 → PCF loads next-PC.
  - Targets are taken as-is; the low two bits are not masked.
- IF/ID register, in priority order:
  - reset.
  - StallD = 1 → all fields hold. Stall beats flush: FlushD with StallD does nothing.
  - FlushD = 1 → InstrD = NOP_INSTR, PCPlus4D = 0, ValidD = 0.
  - else → InstrD = InstrF, PCPlus4D = PCPlus4F, ValidD = 1.
- Latency: an instruction at address A appears on InstrD one cycle after PCF = A, unless stalled or flushed.
- Branch penalty: a redirect asserted in cycle N changes PCF at the edge ending cycle N. The instruction fetched during cycle N must be flushed by the hazard unit via FlushD. This block does not self-flush.
- FetchCount increments by 1 on every edge where the IF/ID register loads a new valid instruction: not reset, StallD = 0, FlushD = 0. It wraps modulo 2^32.
- Held values are not recounted. A stall lasting k cycles adds exactly 1 to the count for that instruction.
- Reset asserted mid-operation, including during a stall or redirect, forces reset values at the next edge. Fetch resumes at RESET_PC on the first cycle after reset deasserts.
- No combinational path from InstrF to any output other than through the IF/ID register.

Test Plan:
- Reset held 3 cycles then released, imem holds words 0x20080001, 0x20090002, ... → PCF sequence 0x0, 0x4, 0x8 after reset; InstrD = 0x20080001 one cycle after PCF = 0x0; ValidD rises with it; FetchCount = 3 after 3 free-running cycles.
- StallF = StallD = 1 for 2 cycles while PCF = 0x10 → PCF stays 0x10, and InstrD/PCPlus4D hold (PCPlus4D = 0x10 for the instruction at 0x0C). FetchCount increases by exactly 1 across the stall window. Fetch resumes at 0x14.
- PCSrcD = 1, PCBranchD = 0x40, FlushD = 1 in the same cycle at PCF = 0x18 → next PCF = 0x40. Next InstrD = NOP_INSTR with ValidD = 0, and FetchCount unchanged. The following InstrD is the word at 0x40.
- JumpD = 1 (PCJumpD = 0x78) and PCSrcD = 1 (PCBranchD = 0x40) together → PCF = 0x78. Then StallF = 1 with a branch pending → PCF holds, and the redirect is dropped.
- FlushD = 1 with StallD = 1 → IF/ID holds its previous valid instruction and ValidD stays 1.
- Reset asserted mid-stream at PCF = 0x5C → one edge later PCF = 0x0, ValidD = 0, FetchCount = 0. Also force PCF = 0xFFFFFFFC with no redirect → next PCF = 0x0 and PCPlus4D = 0x0.
